// File: rtl/demux_rr_sched_if.sv
// demux_rr_sched_if
//   Handshake bundle between one producer, the round-robin demux scheduler
//   and four consumer ports.
//   Signals:
//     in_valid/in_data/in_ready : producer -> scheduler stream
//     out_valid[3:0]            : one-hot "item pending for port i"
//     out_data                  : registered payload shared by all ports
//     out_ready[3:0]            : per-port accept
//     sel_s1/sel_s2             : demux select bits (dest[0], dest[1])
//   Modports: slave = scheduler view, master = environment view.
interface demux_rr_sched_if #(
   parameter int DATA_W = 1
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic [3:0]        out_valid;
   logic [DATA_W-1:0] out_data;
   logic [3:0]        out_ready;
   logic              sel_s1;
   logic              sel_s2;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, sel_s1, sel_s2
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, sel_s1, sel_s2
   );
endinterface

// File: rtl/demux_rr_sched.sv
// demux_rr_sched
//   Round-robin scheduler driving a 1-to-4 demux. A one-entry output register
//   holds the current item; items are sent to ports 0,1,2,3,0,... Select lines
//   use demux encoding {sel_s2,sel_s1} = dest. Counts cycles the held item is
//   blocked by its consumer (saturating).
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     bus        : demux_rr_sched_if.slave handshake bundle
//     stall_cnt  : saturating backpressure stall counter
//     port_en    : per-port rotation enable (only with DEMUX_RR_MASK_EN)
//   Optional feature: define DEMUX_RR_MASK_EN to add port_en; disabled ports
//   are skipped by the rotation and port_en==0 blocks acceptance.
module demux_rr_sched #(
   parameter int DATA_W = 1,
   parameter int CNT_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   demux_rr_sched_if.slave    bus,
`ifdef DEMUX_RR_MASK_EN
   input  logic [3:0]         port_en,
`endif
   output logic [CNT_W-1:0]   stall_cnt
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t            state;
   logic [1:0]        ptr;
   logic [1:0]        dest;
   logic [3:0]        out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic              sel_s1_q;
   logic              sel_s2_q;

   logic              eligible;
   logic              xfer;
   logic              acc;
   logic [1:0]        nxt;

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.sel_s1    = sel_s1_q;
   assign bus.sel_s2    = sel_s2_q;

`ifdef DEMUX_RR_MASK_EN
   assign eligible = |port_en;

   // First enabled port at or after ptr, wrapping mod 4.
   always_comb begin
      logic       found;
      logic [1:0] idx;
      nxt   = ptr;
      found = 1'b0;
      idx   = ptr;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && port_en[idx]) begin
            nxt   = idx;
            found = 1'b1;
         end
      end
   end
`else
   assign eligible = 1'b1;
   assign nxt      = ptr;
`endif

   assign xfer = (state == HOLD) && bus.out_ready[dest];
   // Bypass: a transfer this cycle frees the register for a new item, so
   // in_ready depends combinationally on out_ready (full throughput).
   assign bus.in_ready = !rst && eligible && ((state == IDLE) || xfer);
   assign acc          = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= 2'd0;
         dest        <= 2'd0;
         out_valid_q <= 4'b0;
         out_data_q  <= '0;
         sel_s1_q    <= 1'b0;
         sel_s2_q    <= 1'b0;
         stall_cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (acc) state <= HOLD;
            HOLD: begin
               if (xfer && !acc)
                  state <= IDLE;
               else if (!xfer && stall_cnt != {CNT_W{1'b1}})
                  stall_cnt <= stall_cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase

         // acc can only happen in IDLE or together with a transfer, so the
         // held item is never overwritten while it is still pending.
         if (acc) begin
            out_data_q  <= bus.in_data;
            dest        <= nxt;
            ptr         <= nxt + 2'd1;
            out_valid_q <= 4'(4'b0001 << nxt);
            sel_s1_q    <= nxt[0];
            sel_s2_q    <= nxt[1];
         end else if (xfer) begin
            out_valid_q <= 4'b0;
         end
      end
   end

endmodule
